// File: rtl/start_seq_pkg.sv
// Shared types and constants for the start-lights sequencer and its LFSR.
package start_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIGHT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int LFSR_SEED = 1;

    // Feedback taps for x^7 + x^6 + 1 (bit indices of the 7-bit register).
    localparam int LFSR_TAP_HI = 6;
    localparam int LFSR_TAP_LO = 5;

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR supplying the random hold delay; never reaches zero.
module lfsr_gen
    import start_seq_pkg::*;
#(
    parameter int LFSR_WIDTH = 7
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    output logic [LFSR_WIDTH-1:0] value
);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_WIDTH'(LFSR_SEED);
        end else begin
            value <= {value[LFSR_WIDTH-2:0], value[LFSR_TAP_HI] ^ value[LFSR_TAP_LO]};
        end
    end

endmodule

// File: rtl/start_light_sequencer.sv
// Start-lights controller: lights the bar one LED per tick, holds for a random delay, then pulses go.
// Optional abort input is enabled by defining START_SEQ_ABORT_EN.
module start_light_sequencer
    import start_seq_pkg::*;
#(
    parameter int N_LIGHTS        = 8,
    parameter int LFSR_WIDTH      = 7,
    parameter int MIN_DELAY_TICKS = 1
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                trigger,
    input  logic                tick,
`ifdef START_SEQ_ABORT_EN
    input  logic                abort,
`endif
    output logic                tick_en,
    output logic [N_LIGHTS-1:0] lights,
    output logic                busy,
    output logic                go
);

    localparam int DW = LFSR_WIDTH + 1;

    state_t                state_q, state_d;
    logic [N_LIGHTS-1:0]   lights_d;
    logic                  tick_en_d, busy_d, go_d;
    logic [DW-1:0]         delay_q, delay_d;
    logic [LFSR_WIDTH-1:0] lfsr;

    lfsr_gen #(
        .LFSR_WIDTH(LFSR_WIDTH)
    ) u_lfsr (
        .clkin(clkin),
        .rst_n(rst_n),
        .value(lfsr)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lights  <= '0;
            tick_en <= 1'b0;
            busy    <= 1'b0;
            go      <= 1'b0;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            lights  <= lights_d;
            tick_en <= tick_en_d;
            busy    <= busy_d;
            go      <= go_d;
            delay_q <= delay_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lights_d  = lights;
        tick_en_d = tick_en;
        busy_d    = busy;
        go_d      = 1'b0;
        delay_d   = delay_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d   = LIGHT;
                    tick_en_d = 1'b1;
                    busy_d    = 1'b1;
                    lights_d  = '0;
                end
            end
            LIGHT: begin
                if (tick) begin
                    lights_d = {lights[N_LIGHTS-2:0], 1'b1};
                    // The shift fills the top LED exactly when the one below it is already lit.
                    if (lights[N_LIGHTS-2]) begin
                        state_d = HOLD;
                        delay_d = {1'b0, lfsr} + DW'(MIN_DELAY_TICKS);
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    delay_d = delay_q - DW'(1);
                    if (delay_q == DW'(1)) begin
                        state_d   = IDLE;
                        lights_d  = '0;
                        tick_en_d = 1'b0;
                        busy_d    = 1'b0;
                        go_d      = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                lights_d  = '0;
                tick_en_d = 1'b0;
                busy_d    = 1'b0;
                delay_d   = '0;
            end
        endcase

`ifdef START_SEQ_ABORT_EN
        // Abort overrides whatever a simultaneous tick would have done.
        if (abort && (state_q == LIGHT || state_q == HOLD)) begin
            state_d   = IDLE;
            lights_d  = '0;
            tick_en_d = 1'b0;
            busy_d    = 1'b0;
            go_d      = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_start_light_sequencer.sv
// Directed bench for start_light_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_start_light_sequencer;

    localparam int N = 8;

    logic         clkin = 1'b0;
    logic         rst_n = 1'b0;
    logic         trigger = 1'b0;
    logic         tick = 1'b0;
`ifdef START_SEQ_ABORT_EN
    logic         abort = 1'b0;
`endif
    logic         tick_en, busy, go;
    logic [N-1:0] lights;

    always #5 clkin = ~clkin;

    start_light_sequencer dut (
        .clkin  (clkin),
        .rst_n  (rst_n),
        .trigger(trigger),
        .tick   (tick),
`ifdef START_SEQ_ABORT_EN
        .abort  (abort),
`endif
        .tick_en(tick_en),
        .lights (lights),
        .busy   (busy),
        .go     (go)
    );

    // Reference LFSR: x^7 + x^6 + 1, seeded with 1, advancing every cycle out of reset.
    logic [6:0] m_lfsr;
    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 7'd1;
        else        m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end

    typedef struct {
        logic         trg;
        logic         tk;
        logic [N-1:0] lights;
        logic         te;
        logic         busy;
        logic         go;
    } vec_t;

    vec_t       vecs[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [6:0] pre_lfsr;
    int         d;
    int         remaining;

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_outs(input string name, input logic [N-1:0] l, input logic te,
                              input logic b, input logic g);
        check(name, {lights, tick_en, busy, go}, {l, te, b, g});
    endtask

    // One clock: inputs applied at the falling edge, outputs sampled at the next falling edge.
    task automatic cycle(input logic trg, input logic tk);
        trigger  = trg;
        tick     = tk;
        pre_lfsr = m_lfsr;
        @(posedge clkin);
        @(negedge clkin);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h1F, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h3F, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0});

        repeat (2) @(negedge clkin);
        check_outs("reset_outputs", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_lfsr", 11'(dut.u_lfsr.value), 11'd1);
        rst_n = 1'b1;

        // Idle ticks, trigger acceptance, then lighting up to FF.
        foreach (vecs[i]) begin
            cycle(vecs[i].trg, vecs[i].tk);
            check_outs($sformatf("vec%0d", i), vecs[i].lights, vecs[i].te, vecs[i].busy, vecs[i].go);
        end

        // Hold for lfsr+1 ticks spaced four cycles apart; trigger pulses in between are ignored.
        d = int'(pre_lfsr) + 1;
        for (int j = d; j >= 1; j--) begin
            for (int k = 0; k < 3; k++) begin
                cycle(k == 1, 1'b0);
                check_outs("hold_wait", 8'hFF, 1'b1, 1'b1, 1'b0);
            end
            cycle(1'b0, 1'b1);
            if (j > 1) check_outs("hold_tick", 8'hFF, 1'b1, 1'b1, 1'b0);
            else       check_outs("hold_go", 8'h00, 1'b0, 1'b0, 1'b1);
        end
        cycle(1'b0, 1'b0);
        check_outs("go_clear", 8'h00, 1'b0, 1'b0, 1'b0);

        // Continuous tick with trigger held high: restart on the go cycle.
        cycle(1'b1, 1'b1);
        check_outs("cont_entry", 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= N; i++) begin
            cycle(1'b1, 1'b1);
            check_outs($sformatf("cont_light%0d", i), 8'((1 << i) - 1), 1'b1, 1'b1, 1'b0);
        end
        d = int'(pre_lfsr) + 1;
        for (int j = 1; j <= d; j++) begin
            cycle(1'b1, 1'b1);
            if (j < d) check_outs("cont_hold", 8'hFF, 1'b1, 1'b1, 1'b0);
            else       check_outs("cont_go", 8'h00, 1'b0, 1'b0, 1'b1);
        end
        cycle(1'b1, 1'b1);
        check_outs("retrigger", 8'h00, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        check_outs("restart", 8'h01, 1'b1, 1'b1, 1'b0);

        // Finish lighting, run HOLD down to 5 remaining, then reset asynchronously mid-cycle.
        for (int i = 2; i <= N; i++) begin
            cycle(1'b0, 1'b1);
            check_outs($sformatf("pre_rst_light%0d", i), 8'((1 << i) - 1), 1'b1, 1'b1, 1'b0);
        end
        remaining = int'(pre_lfsr) + 1;
        while (remaining > 5) begin
            cycle(1'b0, 1'b1);
            remaining--;
            check_outs("pre_rst_hold", 8'hFF, 1'b1, 1'b1, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clkin);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1);
            check_outs("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        end

`ifdef START_SEQ_ABORT_EN
        cycle(1'b1, 1'b0);
        check_outs("abort_entry", 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1);
            check_outs("abort_light", 8'((1 << i) - 1), 1'b1, 1'b1, 1'b0);
        end
        abort = 1'b1;
        cycle(1'b0, 1'b1);
        abort = 1'b0;
        check_outs("abort_cut", 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check_outs("abort_idle", 8'h00, 1'b0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
